lbr_drain_ctrl: RTL and testbench
=================================

Name: lbr_drain_ctrl

Overview:
- Sequencer that snapshots the Last Branch Record storage and streams its contents out for a trace/debug consumer, e.g. a DMA writer or debug port.
- Sits beside the LBR unit: freezes branch recording, drives the LBR read select, and walks the circular buffer from top-of-stack (newest) backwards.
- Emits {from, to} address pairs over a valid/ready stream, then releases recording.

Parameters:
- DATA_WIDTH, 32, width of LBR read data and stream data.
- LBR_SIZE, 16, number of LBR entries (power of two, >= 2).
- IW, $clog2(LBR_SIZE), entry index width (derived, localparam).
- SW, IW+2, LBR read-select width (derived, localparam).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle drain request; sampled only in IDLE.
- req_count  in  IW+1  number of entries to drain; 0 means LBR_SIZE; values > LBR_SIZE clamp to LBR_SIZE.
- lbr_freeze  out  1  high while busy; OR'd into the LBR stall so no branch is recorded.
- lbr_read_sel  out  SW  LBR read select. {2'b00,idx} selects FROM, {2'b01,idx} selects TO, 1<<(SW-1) selects TOS.
- lbr_read_data  in  DATA_WIDTH  LBR read data; combinational w.r.t. lbr_read_sel.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_WIDTH  branch address word.
- out_is_to  out  1  0 = FROM word, 1 = TO word.
- out_index  out  IW  age of entry (0 = newest).
- out_last  out  1  final word of the drain (TO of oldest requested entry).
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: FSM to IDLE. All outputs 0, including lbr_read_sel = 0, out_data = 0, lbr_freeze = 0 and done = 0. Internal counters cleared. Reset mid-drain abandons the drain immediately, with no done pulse and no further words.
- FSM states: IDLE, SETTLE, GET_TOS, GET_FROM, EMIT_FROM, GET_TO, EMIT_TO, FINISH.
- IDLE:
  - On start: latch n = (req_count==0 || req_count>LBR_SIZE) ? LBR_SIZE : req_count.
  - Set busy = lbr_freeze = 1 and go to SETTLE.
- SETTLE: one cycle so any in-flight LBR write completes under the freeze. Go to GET_TOS.
- GET_TOS:
  - Drive lbr_read_sel = TOS address.
  - Register ptr = lbr_read_data[IW-1:0] and age = 0.
  - Go to GET_FROM.
- GET_FROM:
  - Drive {2'b00,ptr}.
  - Register the read data into out_data, with out_is_to = 0 and out_index = age.
  - Go to EMIT_FROM.
- EMIT_FROM:
  - out_valid = 1.
  - out_data, out_is_to and out_index are held stable until out_ready.
  - On out_valid & out_ready, go to GET_TO.
- GET_TO: drive {2'b01,ptr}, register the data with out_is_to = 1, go to EMIT_TO.
- EMIT_TO:
  - out_valid = 1, and out_last = (age == n-1).
  - On handshake, if out_last go to FINISH.
  - Otherwise set ptr = ptr-1 (mod LBR_SIZE, wraps 0 -> LBR_SIZE-1), age = age+1, and go to GET_FROM.
- FINISH:
  - done = 1 for exactly one cycle.
  - lbr_freeze and busy drop in the following cycle as the FSM returns to IDLE.
- Throughput: 2 cycles per word when out_ready is held high, giving a minimum latency of start -> first out_valid of 4 cycles.
- out_valid is never retracted before a handshake, and data never changes while out_valid && !out_ready.
- start while busy is ignored and not queued.
- lbr_read_sel holds its last value outside the GET_* states, so no spurious read is implied.
- Arithmetic: ptr and age are IW bits and wrap modulo LBR_SIZE. n is IW+1 bits, so n = LBR_SIZE is representable.
- busy = (state != IDLE). lbr_freeze = busy.

Test Plan:
- LBR_SIZE=16. Preload TOS=3 and FROM/TO[i] = 0x100+i / 0x200+i. start with req_count=2 and out_ready=1 -> 4 words in order: 0x103(F,idx0), 0x203(T,idx0), 0x102(F,idx1), 0x202(T,idx1,last). done pulses 1 cycle after the last handshake, and lbr_freeze is high from the cycle after start until the cycle after done.
- Wrap: TOS=1, req_count=4 -> entry order 1,0,15,14. out_last is set only on TO of entry 14.
- req_count=0 and req_count=20 -> each drains 16 entries (32 words), oldest = TOS+1 mod 16.
- Backpressure: hold out_ready=0 for 5 cycles on each word -> out_valid stays high and out_data/out_is_to/out_index are stable. Word order and count are unchanged, and the LBR sees no writes while frozen, even with branch-taken stimulus applied.
- start pulsed during busy -> ignored, and exactly one drain's worth of words is produced.
- Reset asserted while in EMIT_TO of entry 1 -> next cycle all outputs are 0 and the FSM is in IDLE with no done pulse. A subsequent start performs a full fresh drain from the current TOS.

Source files
------------

// File: rtl/lbr_drain_ctrl.sv
// lbr_drain_ctrl: freezes the LBR, walks it from top-of-stack (newest) backwards
// and streams {FROM, TO} address words over a valid/ready interface.
//   clock, reset     : clock, synchronous active-high reset
//   start, req_count : drain request (sampled in IDLE), entry count (0 => all)
//   lbr_freeze       : holds off LBR recording while busy
//   lbr_read_sel     : LBR read select; lbr_read_data is the combinational reply
//   out_*            : word stream (data, FROM/TO flag, entry age, last word)
//   busy, done       : activity flag, one-cycle completion pulse
module lbr_drain_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LBR_SIZE   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(LBR_SIZE):0]     req_count,
  output logic                          lbr_freeze,
  output logic [$clog2(LBR_SIZE)+1:0]   lbr_read_sel,
  input  logic [DATA_WIDTH-1:0]         lbr_read_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_is_to,
  output logic [$clog2(LBR_SIZE)-1:0]   out_index,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int IW = $clog2(LBR_SIZE);
  localparam int SW = IW + 2;

  localparam logic [IW:0]   NMAX    = (IW+1)'(LBR_SIZE);
  localparam logic [SW-1:0] SEL_TOS = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    GET_TOS,
    GET_FROM,
    EMIT_FROM,
    GET_TO,
    EMIT_TO,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [IW:0]           n_q;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         age_q;
  logic [SW-1:0]         sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  is_to_q;
  logic [IW-1:0]         index_q;

  logic [IW:0]           n_start;
  logic                  is_last;

  assign n_start = (req_count == '0 || req_count > NMAX) ? NMAX : req_count;
  assign is_last = ({1'b0, age_q} == (n_q - 1'b1));

  assign out_data  = data_q;
  assign out_is_to = is_to_q;
  assign out_index = index_q;

  always_comb begin
    state_d      = state_q;
    lbr_read_sel = sel_q;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    done         = 1'b0;
    busy         = (state_q != IDLE);
    lbr_freeze   = (state_q != IDLE);

    unique case (state_q)
      IDLE:      if (start) state_d = SETTLE;
      SETTLE:    state_d = GET_TOS;
      GET_TOS: begin
        lbr_read_sel = SEL_TOS;
        state_d      = GET_FROM;
      end
      GET_FROM: begin
        lbr_read_sel = {2'b00, ptr_q};
        state_d      = EMIT_FROM;
      end
      EMIT_FROM: begin
        out_valid = 1'b1;
        if (out_ready) state_d = GET_TO;
      end
      GET_TO: begin
        lbr_read_sel = {2'b01, ptr_q};
        state_d      = EMIT_TO;
      end
      EMIT_TO: begin
        out_valid = 1'b1;
        out_last  = is_last;
        if (out_ready) state_d = is_last ? FINISH : GET_FROM;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase

    // Select register follows the driven value so it holds outside GET_* states.
    sel_d = lbr_read_sel;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      ptr_q   <= '0;
      age_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      is_to_q <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      unique case (state_q)
        IDLE: if (start) n_q <= n_start;
        GET_TOS: begin
          ptr_q <= lbr_read_data[IW-1:0];
          age_q <= '0;
        end
        GET_FROM: begin
          data_q  <= lbr_read_data;
          is_to_q <= 1'b0;
          index_q <= age_q;
        end
        GET_TO: begin
          data_q  <= lbr_read_data;
          is_to_q <= 1'b1;
          index_q <= age_q;
        end
        EMIT_TO: begin
          // Step to the next older entry; ptr wraps 0 -> LBR_SIZE-1.
          if (out_ready && !is_last) begin
            ptr_q <= ptr_q - 1'b1;
            age_q <= age_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbr_drain_ctrl.sv
// Testbench for lbr_drain_ctrl: LBR storage model, expected-word queue model and
// directed drain scenarios (basic, wrap, full, backpressure, start-while-busy, reset).
module tb_lbr_drain_ctrl;
  localparam int DW = 32;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int SW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [IW:0]   req_count;
  logic          lbr_freeze;
  logic [SW-1:0] lbr_read_sel;
  logic [DW-1:0] lbr_read_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_is_to;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  lbr_drain_ctrl #(.DATA_WIDTH(DW), .LBR_SIZE(N)) dut (
    .clock(clock), .reset(reset), .start(start), .req_count(req_count),
    .lbr_freeze(lbr_freeze), .lbr_read_sel(lbr_read_sel), .lbr_read_data(lbr_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_to(out_is_to), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // LBR storage model; branch writes are blocked while frozen.
  logic [DW-1:0] from_mem [N];
  logic [DW-1:0] to_mem   [N];
  logic [IW-1:0] tos;
  logic          mem_init = 1'b0;
  logic [IW-1:0] tos_val  = '0;
  logic          br_taken = 1'b0;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < N; i++) begin
        from_mem[i] <= 32'h100 + i;
        to_mem[i]   <= 32'h200 + i;
      end
      tos <= tos_val;
    end else if (br_taken && !lbr_freeze) begin
      tos                <= tos + 4'd1;
      from_mem[tos+4'd1] <= $urandom;
      to_mem[tos+4'd1]   <= $urandom;
    end
  end

  always_comb begin
    if (lbr_read_sel[SW-1])      lbr_read_data = 32'(tos);
    else if (lbr_read_sel[SW-2]) lbr_read_data = to_mem[lbr_read_sel[IW-1:0]];
    else                         lbr_read_data = from_mem[lbr_read_sel[IW-1:0]];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Ready/branch driver: ready high, or 5 stalled cycles per word in bp_mode.
  logic bp_mode = 1'b0;
  int   hold    = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (!bp_mode) begin
        out_ready = 1'b1;
        br_taken  = 1'b0;
      end else begin
        br_taken = busy && ($urandom_range(0, 1) == 1);
        if (out_valid) begin
          if (hold < 5) begin out_ready = 1'b0; hold++; end
          else begin out_ready = 1'b1; hold = 0; end
        end else begin
          out_ready = 1'b0;
          hold      = 0;
        end
      end
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          is_to;
    logic [IW-1:0] idx;
    logic          last;
    int            cyc;
  } word_t;

  word_t exp_q[$];
  word_t log_q[$];
  int    start_cyc = 0;
  int    done_cyc  = 0;
  int    done_cnt  = 0;
  logic  armed     = 1'b0;
  logic  mbusy     = 1'b0;
  logic  done_due  = 1'b0;

  // Expected word list: newest entry first, FROM then TO, last on TO of oldest.
  function automatic void build(input logic [IW:0] rc);
    int    n;
    int    e;
    word_t w;
    n = (rc == 0 || rc > N) ? N : int'(rc);
    for (int k = 0; k < n; k++) begin
      e       = (int'(tos) - k) & (N - 1);
      w.cyc   = 0;
      w.idx   = IW'(k);
      w.data  = from_mem[e]; w.is_to = 1'b0; w.last = 1'b0;
      exp_q.push_back(w);
      w.data  = to_mem[e];   w.is_to = 1'b1; w.last = (k == n - 1);
      exp_q.push_back(w);
    end
  endfunction

  logic          pv = 1'b0, pr = 1'b0, pt;
  logic [DW-1:0] pd;
  logic [IW-1:0] pi;
  logic [SW-1:0] ps;

  always @(negedge clock) begin : cmp
    word_t w;
    logic  nd;
    if (armed) begin
      chk("busy", busy, mbusy);
      chk("freeze", lbr_freeze, mbusy);
      chk("done", done, done_due);
      if (done) begin done_cyc = cyc; done_cnt++; end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          chk("data", out_data, exp_q[0].data);
          chk("is_to", out_is_to, exp_q[0].is_to);
          chk("index", out_index, exp_q[0].idx);
          chk("last", out_last, exp_q[0].last);
        end
      end else chk("last_no_valid", out_last, 0);
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_is_to", out_is_to, pt);
        chk("hold_index", out_index, pi);
        chk("hold_sel", lbr_read_sel, ps);
      end
      if (reset) begin
        exp_q.delete();
        mbusy    = 1'b0;
        done_due = 1'b0;
        pv       = 1'b0;
      end else begin
        nd = 1'b0;
        if (out_valid && out_ready && exp_q.size() > 0) begin
          w     = exp_q.pop_front();
          w.cyc = cyc;
          log_q.push_back(w);
          nd    = w.last;
        end
        if (done_due) mbusy = 1'b0;
        else if (!mbusy && start) begin
          build(req_count);
          mbusy     = 1'b1;
          start_cyc = cyc;
        end
        done_due = nd;
        pv = out_valid; pr = out_ready; pd = out_data;
        pt = out_is_to; pi = out_index; ps = lbr_read_sel;
      end
    end
  end

  task automatic load(input logic [IW-1:0] t);
    mem_init = 1'b1;
    tos_val  = t;
    @(posedge clock); #1;
    mem_init = 1'b0;
    log_q.delete();
  endtask

  task automatic drain(input logic [IW:0] rc);
    start     = 1'b1;
    req_count = rc;
    @(posedge clock); #1;
    start     = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_freeze"}, lbr_freeze, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_sel"}, lbr_read_sel, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_is_to"}, out_is_to, 0);
    chk({tag, "_index"}, out_index, 0);
  endtask

  initial begin
    int n;
    int dc;
    reset = 1'b1; start = 1'b0; req_count = '0;
    repeat (3) @(posedge clock);
    #1;
    load(4'd3);
    @(negedge clock);
    zero_outputs("rst");
    @(posedge clock); #1;
    reset = 1'b0;
    armed = 1'b1;
    @(posedge clock); #1;

    // Basic: TOS=3, two entries, ready held high.
    load(4'd3);
    drain(5'd2);
    wait_idle();
    chk("t1_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t1_w0", log_q[0].data, 32'h103);
      chk("t1_w1", log_q[1].data, 32'h203);
      chk("t1_w2", log_q[2].data, 32'h102);
      chk("t1_w3", log_q[3].data, 32'h202);
      chk("t1_idx2", log_q[2].idx, 1);
      chk("t1_last3", log_q[3].last, 1);
      for (int i = 0; i < 4; i++)
        chk("t1_cycle", log_q[i].cyc - start_cyc, 4 + 2 * i);
    end
    chk("t1_done_cycle", done_cyc - start_cyc, 11);

    // Wrap: TOS=1, four entries -> 1,0,15,14.
    load(4'd1);
    drain(5'd4);
    wait_idle();
    chk("t2_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      chk("t2_e0", log_q[0].data, 32'h101);
      chk("t2_e1", log_q[2].data, 32'h100);
      chk("t2_e2", log_q[4].data, 32'h10F);
      chk("t2_e3", log_q[6].data, 32'h10E);
      for (int i = 0; i < 8; i++) chk("t2_last", log_q[i].last, (i == 7));
    end

    // Full drains: req 0 and req 20 both mean 16 entries.
    load(4'd5);
    drain(5'd0);
    wait_idle();
    chk("t3a_count", log_q.size(), 32);
    if (log_q.size() == 32) begin
      chk("t3a_first", log_q[0].data, 32'h105);
      chk("t3a_oldest", log_q[31].data, 32'h206);
    end
    load(4'd5);
    drain(5'd20);
    wait_idle();
    chk("t3b_count", log_q.size(), 32);
    if (log_q.size() == 32) chk("t3b_oldest", log_q[31].data, 32'h206);

    // Backpressure with branch stimulus while frozen.
    load(4'd7);
    bp_mode = 1'b1;
    drain(5'd3);
    wait_idle();
    bp_mode = 1'b0;
    chk("t4_count", log_q.size(), 6);
    if (log_q.size() == 6) begin
      chk("t4_first", log_q[0].data, 32'h107);
      chk("t4_oldest", log_q[5].data, 32'h205);
      chk("t4_gap", log_q[1].cyc - log_q[0].cyc, 7);
    end

    // Start while busy is ignored.
    load(4'd2);
    drain(5'd3);
    repeat (3) @(posedge clock);
    #1;
    drain(5'd5);
    wait_idle();
    repeat (10) @(posedge clock);
    #1;
    chk("t5_count", log_q.size(), 6);
    if (log_q.size() == 6) chk("t5_oldest", log_q[5].data, 32'h200);
    chk("t5_idle", busy, 0);

    // Reset while emitting TO of entry 1, then a fresh full drain.
    load(4'd9);
    drain(5'd4);
    n = 0;
    while (!(out_valid && out_is_to && out_index == 4'd1) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("t6_reach_to1", n < 100, 1);
    dc    = done_cnt;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    zero_outputs("t6");
    chk("t6_words", log_q.size(), 3);
    repeat (5) @(posedge clock);
    #1;
    chk("t6_no_done", done_cnt, dc);
    log_q.delete();
    drain(5'd0);
    wait_idle();
    chk("t6_fresh_count", log_q.size(), 32);
    if (log_q.size() == 32) begin
      chk("t6_fresh_first", log_q[0].data, 32'h109);
      chk("t6_fresh_oldest", log_q[31].data, 32'h20A);
    end

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
